// File: rtl/output_quant_buffer_pkg.sv
// Shared types and helpers for the output quantize buffer: saturation limits,
// the FIFO entry layout and a reference requantize function.
package output_quant_buffer_pkg;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 16;
    localparam int COORD_W = 32;

    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic signed [OUT_W-1:0]   data;
        logic        [COORD_W-1:0] x;
        logic        [COORD_W-1:0] y;
        logic        [COORD_W-1:0] ch;
    } qbuf_entry_t;

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic signed [OUT_W-1:0] quantize(
        input logic signed [ACC_W-1:0] acc,
        input logic        [4:0]       shift,
        input logic                    relu
    );
        logic signed [ACC_W:0] wide;
        wide = {acc[ACC_W-1], acc};
        if (shift != 5'd0) begin
            wide = wide + ((ACC_W+1)'(1) << (shift - 5'd1));
        end
        wide = wide >>> shift;
        if (relu && wide[ACC_W]) begin
            wide = '0;
        end
        if (wide > (ACC_W+1)'(SAT_MAX)) begin
            return SAT_MAX;
        end
        if (wide < (ACC_W+1)'(SAT_MIN)) begin
            return SAT_MIN;
        end
        return wide[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/output_quant_buffer_if.sv
// Producer-side capture signals and host-side valid/ready stream of the
// output quantize buffer, bundled for connection between host and block.
interface output_quant_buffer_if
    import output_quant_buffer_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_W,
    parameter int OUT_WIDTH   = OUT_W,
    parameter int COORD_WIDTH = COORD_W
);

    logic                          in_valid;
    logic signed [ACC_WIDTH-1:0]   in_data;
    logic        [COORD_WIDTH-1:0] in_x;
    logic        [COORD_WIDTH-1:0] in_y;
    logic        [COORD_WIDTH-1:0] in_ch;
    logic        [4:0]             quant_shift;
    logic                          relu_en;

    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic        [COORD_WIDTH-1:0] out_x;
    logic        [COORD_WIDTH-1:0] out_y;
    logic        [COORD_WIDTH-1:0] out_ch;

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, quant_shift, relu_en,
        output out_ready,
        input  out_valid, out_data, out_x, out_y, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, quant_shift, relu_en,
        input  out_ready,
        output out_valid, out_data, out_x, out_y, out_ch
    );

endinterface

// File: rtl/output_quant_buffer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: the head entry is readable on
// rdata whenever empty is low, one cycle after it was written.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO only lands when a pop frees a slot that cycle.
    always_comb begin
        doPop   = pop && !empty;
        doPush  = push && (!full || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata;
        end
    end

    assign rdata = mem[rdPtr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/output_quant_buffer.sv
// Captures convolution results, requantizes them to OUT_WIDTH with rounding,
// optional ReLU and saturation, and queues them for the host stream.
module output_quant_buffer
    import output_quant_buffer_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_W,
    parameter int OUT_WIDTH   = OUT_W,
    parameter int COORD_WIDTH = COORD_W,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              arst_n_in,
    output_quant_buffer_if.slave              bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
    output logic                              overflow,
    input  logic                              clear_overflow
);

    localparam int ENTRY_WIDTH = OUT_WIDTH + 3 * COORD_WIDTH;
    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'(SAT_MAX);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH+1)'(SAT_MIN);

    logic        [ACC_WIDTH:0]   roundBit;
    logic signed [ACC_WIDTH:0]   roundedSum;
    logic signed [ACC_WIDTH:0]   shiftedSum;
    logic signed [OUT_WIDTH-1:0] quantized;

    logic        stageValid_q, stageValid_d;
    qbuf_entry_t stageEntry_q, stageEntry_d;
    logic        overflow_q, overflow_d;

    qbuf_entry_t headEntry;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        popReq;
    logic        dropPush;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount;

    // Requantize: add half an LSB of the target scale, arithmetic shift,
    // then clamp negatives (ReLU) and saturate into the output range.
    always_comb begin
        roundBit = '0;
        if (bus.quant_shift != 5'd0) begin
            roundBit = (ACC_WIDTH+1)'(1) << (bus.quant_shift - 5'd1);
        end
        roundedSum = $signed({bus.in_data[ACC_WIDTH-1], bus.in_data} + roundBit);
        shiftedSum = roundedSum >>> bus.quant_shift;
        if (bus.relu_en && shiftedSum[ACC_WIDTH]) begin
            shiftedSum = '0;
        end
        if (shiftedSum > SAT_HI) begin
            quantized = SAT_MAX;
        end else if (shiftedSum < SAT_LO) begin
            quantized = SAT_MIN;
        end else begin
            quantized = shiftedSum[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        stageValid_d = bus.in_valid;
        stageEntry_d = stageEntry_q;
        if (bus.in_valid) begin
            stageEntry_d.data = quantized;
            stageEntry_d.x    = bus.in_x;
            stageEntry_d.y    = bus.in_y;
            stageEntry_d.ch   = bus.in_ch;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stageValid_q <= 1'b0;
            stageEntry_q <= '0;
        end else begin
            stageValid_q <= stageValid_d;
            stageEntry_q <= stageEntry_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .push      (stageValid_q),
        .pop       (popReq),
        .wdata     (stageEntry_q),
        .rdata     (headEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (fifoCount)
    );

    // The producer cannot stall, so a push into a full FIFO with no pop is lost.
    always_comb begin
        popReq     = bus.out_ready && !fifoEmpty;
        dropPush   = stageValid_q && fifoFull && !popReq;
        overflow_d = overflow_q;
        if (dropPush) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        bus.out_valid = !fifoEmpty;
        bus.out_data  = '0;
        bus.out_x     = '0;
        bus.out_y     = '0;
        bus.out_ch    = '0;
        if (!fifoEmpty) begin
            bus.out_data = headEntry.data;
            bus.out_x    = headEntry.x;
            bus.out_y    = headEntry.y;
            bus.out_ch   = headEntry.ch;
        end
    end

    assign fill_level = fifoCount;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_output_quant_buffer.sv
// Directed bench for output_quant_buffer: expected entries are queued when
// driven and checked in order as the host stream accepts them.
module tb_output_quant_buffer;
    import output_quant_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       arst_n_in = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [3:0] fill_level;
    logic       overflow;

    int          compareCount  = 0;
    int          mismatchCount = 0;
    int          coordSeq      = 0;
    qbuf_entry_t expQ[$];

    always #5 clk = ~clk;

    output_quant_buffer_if #(
        .ACC_WIDTH   (ACC_W),
        .OUT_WIDTH   (OUT_W),
        .COORD_WIDTH (COORD_W)
    ) bus ();

    output_quant_buffer #(
        .ACC_WIDTH   (ACC_W),
        .OUT_WIDTH   (OUT_W),
        .COORD_WIDTH (COORD_W),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk            (clk),
        .arst_n_in      (arst_n_in),
        .bus            (bus),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one result for a single cycle; keep=0 marks entries the DUT must discard.
    task automatic applyStimulus(input logic signed [31:0] data, input logic [4:0] shift,
                                 input logic relu, input logic signed [15:0] expData,
                                 input bit keep);
        qbuf_entry_t e;
        @(posedge clk);
        #1;
        coordSeq++;
        bus.in_valid    = 1'b1;
        bus.in_data     = data;
        bus.quant_shift = shift;
        bus.relu_en     = relu;
        bus.in_x        = 32'(coordSeq);
        bus.in_y        = 32'(coordSeq * 3 + 7);
        bus.in_ch       = 32'(coordSeq) ^ 32'h0000_00A5;
        if (keep) begin
            e.data = expData;
            e.x    = bus.in_x;
            e.y    = bus.in_y;
            e.ch   = bus.in_ch;
            expQ.push_back(e);
        end
    endtask

    task automatic applyRandom(input bit keep);
        logic signed [31:0] d;
        logic [4:0]         s;
        logic               r;
        d = $urandom;
        s = 5'($urandom_range(0, 31));
        r = 1'($urandom_range(0, 1));
        applyStimulus(d, s, r, quantize(d, s, r), keep);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic setReady(input logic v);
        @(posedge clk);
        #1;
        bus.out_ready = v;
    endtask

    task automatic waitDrain();
        int c = 0;
        while (expQ.size() != 0 && c < 64) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        checkOutput("drain_complete", longint'(expQ.size()), 0);
        checkOutput("drain_fill_level", longint'(fill_level), 0);
    endtask

    // Scoreboard: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_output", longint'(expQ.size() != 0), 1);
            end else begin
                qbuf_entry_t e;
                e = expQ.pop_front();
                checkOutput("out_data", longint'($signed(bus.out_data)), longint'($signed(e.data)));
                checkOutput("out_x", longint'(bus.out_x), longint'(e.x));
                checkOutput("out_y", longint'(bus.out_y), longint'(e.y));
                checkOutput("out_ch", longint'(bus.out_ch), longint'(e.ch));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [15:0] headData;
        logic [31:0]        headX;

        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_x        = '0;
        bus.in_y        = '0;
        bus.in_ch       = '0;
        bus.quant_shift = '0;
        bus.relu_en     = 1'b0;
        bus.out_ready   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
        checkOutput("reset_fill_level", longint'(fill_level), 0);
        checkOutput("reset_overflow", longint'(overflow), 0);
        checkOutput("reset_out_data", longint'($signed(bus.out_data)), 0);
        arst_n_in = 1'b1;

        // Basic path and two-cycle latency
        applyStimulus(32'sd1000, 5'd3, 1'b0, 16'sd125, 1'b1);
        bus.out_ready = 1'b1;
        idleCycles(1);
        @(negedge clk);
        checkOutput("latency_not_early", longint'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("latency_valid", longint'(bus.out_valid), 1);
        checkOutput("basic_data", longint'($signed(bus.out_data)), 125);
        checkOutput("basic_x", longint'(bus.out_x), 1);
        @(negedge clk);
        checkOutput("basic_empty_after_pop", longint'(bus.out_valid), 0);
        checkOutput("basic_fill_zero", longint'(fill_level), 0);

        // Rounding, ReLU and saturation corners
        applyStimulus(-32'sd20, 5'd2, 1'b0, -16'sd5, 1'b1);
        applyStimulus(-32'sd20, 5'd2, 1'b1, 16'sd0, 1'b1);
        applyStimulus(32'sh7FFF_FFFF, 5'd0, 1'b0, 16'sd32767, 1'b1);
        applyStimulus(32'sh8000_0000, 5'd0, 1'b0, -16'sd32768, 1'b1);
        applyStimulus(32'sd7, 5'd1, 1'b0, 16'sd4, 1'b1);
        applyStimulus(32'sh7FFF_FFFF, 5'd31, 1'b0, 16'sd1, 1'b1);
        idleCycles(1);
        waitDrain();

        // Backpressure, full FIFO and a dropped ninth entry
        setReady(1'b0);
        for (int i = 0; i < 8; i++) applyRandom(1'b1);
        idleCycles(2);
        @(negedge clk);
        headData = expQ[0].data;
        headX    = expQ[0].x;
        checkOutput("full_fill_level", longint'(fill_level), 8);
        checkOutput("full_no_overflow", longint'(overflow), 0);
        checkOutput("full_head_data", longint'($signed(bus.out_data)), longint'(headData));
        applyRandom(1'b0);
        idleCycles(2);
        @(negedge clk);
        checkOutput("drop_overflow_set", longint'(overflow), 1);
        checkOutput("drop_fill_level", longint'(fill_level), 8);
        checkOutput("drop_head_stable", longint'($signed(bus.out_data)), longint'(headData));
        checkOutput("drop_head_x_stable", longint'(bus.out_x), longint'(headX));
        setReady(1'b1);
        waitDrain();
        checkOutput("overflow_sticky", longint'(overflow), 1);
        @(posedge clk); #1; clear_overflow = 1'b1;
        @(posedge clk); #1; clear_overflow = 1'b0;
        @(negedge clk);
        checkOutput("overflow_cleared", longint'(overflow), 0);

        // Full FIFO with simultaneous push and pop every cycle
        setReady(1'b0);
        for (int i = 0; i < 8; i++) applyRandom(1'b1);
        idleCycles(2);
        for (int i = 0; i < 20; i++) begin
            applyRandom(1'b1);
            if (i == 1) bus.out_ready = 1'b1;
            @(negedge clk);
            checkOutput("stream_fill_level", longint'(fill_level), 8);
            checkOutput("stream_no_overflow", longint'(overflow), 0);
        end
        idleCycles(1);
        waitDrain();

        // Set wins over clear in the same cycle
        setReady(1'b0);
        for (int i = 0; i < 8; i++) applyRandom(1'b1);
        idleCycles(2);
        applyRandom(1'b0);
        @(posedge clk); #1; bus.in_valid = 1'b0; clear_overflow = 1'b1;
        @(posedge clk); #1; clear_overflow = 1'b0;
        @(negedge clk);
        checkOutput("priority_set_wins", longint'(overflow), 1);
        @(posedge clk); #1; clear_overflow = 1'b1;
        @(posedge clk); #1; clear_overflow = 1'b0;
        @(negedge clk);
        checkOutput("priority_clear_alone", longint'(overflow), 0);
        setReady(1'b1);
        waitDrain();

        // Reset mid-stream: five buffered entries plus one in the stage register
        setReady(1'b0);
        for (int i = 0; i < 6; i++) applyRandom(1'b0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("prereset_fill_level", longint'(fill_level), 5);
        #2;
        arst_n_in = 1'b0;
        #1;
        checkOutput("midreset_out_valid", longint'(bus.out_valid), 0);
        checkOutput("midreset_fill_level", longint'(fill_level), 0);
        @(negedge clk);
        arst_n_in = 1'b1;
        applyStimulus(-32'sd300, 5'd4, 1'b0, -16'sd19, 1'b1);
        bus.out_ready = 1'b1;
        idleCycles(1);
        @(negedge clk);
        checkOutput("postreset_no_stale", longint'(bus.out_valid), 0);
        @(negedge clk);
        checkOutput("postreset_valid", longint'(bus.out_valid), 1);
        checkOutput("postreset_data", longint'($signed(bus.out_data)), -19);
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/output_quant_buffer.md
Name: output_quant_buffer

Overview:
- Sits directly downstream of the convolution controller/datapath.
- Captures each finished output (accumulator value plus x/y/ch coordinates) on output_valid; the producer cannot stall, so capture is unconditional.
- Requantizes the 32-bit accumulator to a narrower signed word (rounding shift, optional ReLU, saturation).
- Buffers results in a small FIFO and presents them to the host over a valid/ready stream; overflow is flagged, never back-pressured.

Parameters:
- ACC_WIDTH, 32, accumulator input width (signed).
- OUT_WIDTH, 16, quantized output width (signed).
- COORD_WIDTH, 32, width of x/y/ch coordinates.
- FIFO_DEPTH, 8, number of buffered entries; power of 2, ≥2.

Ports:
- clk  in  1  clock
- arst_n_in  in  1  asynchronous reset, active low
- in_valid  in  1  producer output_valid; one result per asserted cycle
- in_data  in  ACC_WIDTH  signed accumulator value
- in_x / in_y / in_ch  in  COORD_WIDTH each  coordinates of in_data
- quant_shift  in  5  right-shift amount 0..31; sampled with in_valid
- relu_en  in  1  clamp negatives to 0; sampled with in_valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  host accepts head
- out_data  out  OUT_WIDTH  quantized value at head
- out_x / out_y / out_ch  out  COORD_WIDTH each  head coordinates
- fill_level  out  $clog2(FIFO_DEPTH+1)  number of entries held
- overflow  out  1  sticky: a result was dropped
- clear_overflow  in  1  clears overflow

Behaviour:
- Reset (async, arst_n_in=0): pointers, fill_level, stage register valid and overflow go to 0; out_valid=0; out_data/out_x/out_y/out_ch=0. Reset mid-stream discards all buffered and in-flight entries.
- Stage 1 (quantize register), loaded when in_valid=1:
  - r = in_data + (quant_shift>0 ? 1<<(quant_shift-1) : 0), computed at ACC_WIDTH+1 bits, no wrap.
  - q = r >>> quant_shift (arithmetic).
  - If relu_en and q<0: q=0.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Coordinates pass through unchanged.
  - Stage valid bit = in_valid of previous cycle.
- Stage 2 (FIFO write):
  - Stage valid pushes {q, x, y, ch} into the FIFO at the end of that cycle.
  - FIFO is first-word-fall-through: head is registered and visible the cycle after the write.
- Latency: in_valid at cycle N → out_valid at N+2 when the FIFO is empty.
- Throughput: one entry per cycle in and out.
- Pop occurs when out_valid && out_ready. While out_valid=1 and out_ready=0, out_data and coordinates are held stable.
- Full FIFO:
  - Push with a simultaneous pop is accepted; fill_level is unchanged.
  - Push without a pop drops the new entry and sets overflow=1 next cycle; FIFO contents are untouched.
- Empty FIFO: out_valid=0; out_ready is ignored; fill_level never underflows.
- Push and pop in the same cycle while empty: there is no bypass; the entry appears the next cycle.
- Pointers wrap modulo FIFO_DEPTH. fill_level = pushes - pops, range 0..FIFO_DEPTH.
- overflow:
  - Set has priority over clear_overflow in the same cycle.
  - Otherwise clear_overflow drives it to 0 the next cycle.
- No FSM beyond the FIFO occupancy counter. Stage and FIFO run continuously after reset.

Decomposition:
- Shared package: OUT_WIDTH-dependent saturation limits (SAT_MAX, SAT_MIN).
- Also in the package: a packed struct type for the FIFO entry {data, x, y, ch}.
- Also in the package: a function quantize(acc, shift, relu) that the golden model in the testbench reuses.
- One sub-module: sync_fifo_fwft.
  - Parameterized width and depth.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Instantiated once.
- Quantize stage remains in the top.

Test Plan:
1. Basic path: in_data=1000, shift=3, relu_en=0, x=1 y=2 ch=5, out_ready=1 → out_valid at N+2 with out_data=125 (1000+4)>>3, coordinates 1/2/5, fill_level back to 0.
2. Rounding/ReLU/saturation:
   - in_data=-20, shift=2, relu_en=0 → -5.
   - Same with relu_en=1 → 0.
   - in_data=0x7FFFFFFF, shift=0 → 32767.
   - in_data=0x80000000, shift=0 → -32768.
   - in_data=7, shift=1 → 4.
3. Backpressure: out_ready=0, push 8 entries → fill_level=8, head stable, overflow=0. A 9th push sets overflow=1 and the 9th entry is lost. Draining yields exactly entries 1..8 in order.
4. Full with simultaneous pop: FIFO at 8, out_ready=1 and in_valid every cycle for 20 cycles → no overflow, fill_level stays 8, output order matches input order.
5. Overflow priority: clear_overflow=1 in the same cycle as a dropping push → overflow stays 1. clear_overflow alone on the next cycle → overflow=0.
6. Reset mid-stream: 5 entries buffered and one in stage 1, then assert arst_n_in → out_valid=0 and fill_level=0 immediately. After release, a new input appears at N+2 with no stale data.
